// File: rtl/battleship_attack_engine.sv
// Battleship attack datapath: latches the ship map on attack entry, tracks fired cells,
// scores shots against a budget, times RGB feedback and reports win/lose.
module battleship_attack_engine #(
    parameter int COLS            = 5,
    parameter int ROWS            = 7,
    parameter int MAX_SHOTS       = 20,
    parameter int FEEDBACK_CYCLES = 3000,
    localparam int N  = COLS * ROWS,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS),
    localparam int SW = $clog2(MAX_SHOTS + 1),
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    game_state_code,
    input  logic [N-1:0]  map,
    input  logic [XW-1:0] x_coord,
    input  logic [YW-1:0] y_coord,
    input  logic          confirm_attack,
    output logic [N-1:0]  matrix_data,
    output logic [1:0]    led_rgb,
    output logic [SW-1:0] shots_left,
    output logic [CW-1:0] hits_count,
    output logic          game_over,
    output logic          win
);

    localparam int TW = $clog2(FEEDBACK_CYCLES + 1);
    localparam int IW = $clog2(N);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] FEEDBACK = 2'd2;
    localparam logic [1:0] OVER     = 2'd3;

    logic [1:0]    state;
    logic [N-1:0]  saved_map;
    logic [N-1:0]  fired;
    logic [CW-1:0] targets;
    logic [TW-1:0] timer;
    logic          press_prev;

    logic          attack;
    logic          press;
    logic          in_range;
    logic [IW-1:0] cell_idx;
    logic          cell_fired;
    logic          cell_ship;

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    // NOTE: every signal written in always_comb gets a value on every path first, so no latch is inferred.
    always_comb begin
        attack     = (game_state_code == 2'b10);
        press      = press_prev & ~confirm_attack;
        in_range   = (int'(x_coord) < COLS) && (int'(y_coord) < ROWS);
        cell_idx   = IW'((COLS - 1 - int'(x_coord)) * ROWS + int'(y_coord));
        cell_fired = fired[cell_idx];
        cell_ship  = saved_map[cell_idx];
    end

    always_comb begin
        matrix_data = '0;
        case (game_state_code)
            2'b00:   matrix_data = '0;
            2'b10:   matrix_data = ~fired | saved_map;
            default: matrix_data = map;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            saved_map  <= '0;
            fired      <= '0;
            targets    <= '0;
            timer      <= '0;
            hits_count <= '0;
            shots_left <= SW'(MAX_SHOTS);
            led_rgb    <= 2'b00;
            game_over  <= 1'b0;
            win        <= 1'b0;
            press_prev <= 1'b1;
        end else begin
            press_prev <= confirm_attack;
            if (state != IDLE && !attack) begin
                // Leaving attack mode keeps counters and history until the next entry.
                state     <= IDLE;
                led_rgb   <= 2'b00;
                game_over <= 1'b0;
                win       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (attack) begin
                            saved_map  <= map;
                            fired      <= '0;
                            hits_count <= '0;
                            shots_left <= SW'(MAX_SHOTS);
                            targets    <= popcount(map);
                            game_over  <= 1'b0;
                            win        <= 1'b0;
                            state      <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (targets == '0) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            win       <= 1'b1;
                            led_rgb   <= 2'b01;
                        end else if (press && in_range) begin
                            timer <= TW'(FEEDBACK_CYCLES);
                            state <= FEEDBACK;
                            if (cell_fired) begin
                                led_rgb <= 2'b11;
                            end else begin
                                fired[cell_idx] <= 1'b1;
                                if (shots_left != '0) shots_left <= shots_left - SW'(1);
                                if (cell_ship) begin
                                    if (hits_count != targets) hits_count <= hits_count + CW'(1);
                                    led_rgb <= 2'b01;
                                end else begin
                                    led_rgb <= 2'b10;
                                end
                            end
                        end
                    end
                    FEEDBACK: begin
                        if (timer <= TW'(1)) begin
                            led_rgb <= 2'b00;
                            // A final shot that sinks the last cell is a win even with no shots left.
                            if (hits_count == targets) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                                win       <= 1'b1;
                                led_rgb   <= 2'b01;
                            end else if (shots_left == '0) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                                win       <= 1'b0;
                                led_rgb   <= 2'b10;
                            end else begin
                                state <= ARMED;
                            end
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    OVER: begin
                        game_over <= 1'b1;
                        led_rgb   <= win ? 2'b01 : 2'b10;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_battleship_attack_engine.sv
// Self-checking bench: directed game on the default instance, shot-budget and held-button
// cases on a 2-shot instance, table vectors and random games against a grid model.
module tb_battleship_attack_engine;

    localparam int FA = 3000;
    localparam int FB = 50;
    localparam int FC = 3;
    localparam logic [34:0] ALL1 = {35{1'b1}};

    logic clk;
    logic reset;

    logic [1:0]  a_code, b_code, c_code;
    logic [34:0] a_map, b_map, c_map;
    logic [2:0]  a_x, a_y, b_x, b_y, c_x, c_y;
    logic        a_btn, b_btn, c_btn;
    logic [34:0] a_md, b_md, c_md;
    logic [1:0]  a_led, b_led, c_led;
    logic [4:0]  a_shots;
    logic [1:0]  b_shots;
    logic [3:0]  c_shots;
    logic [5:0]  a_hits, b_hits, c_hits;
    logic        a_over, b_over, c_over;
    logic        a_win, b_win, c_win;

    int n_cmp  = 0;
    int n_fail = 0;

    battleship_attack_engine dut_a (
        .clk(clk), .reset(reset), .game_state_code(a_code), .map(a_map),
        .x_coord(a_x), .y_coord(a_y), .confirm_attack(a_btn), .matrix_data(a_md),
        .led_rgb(a_led), .shots_left(a_shots), .hits_count(a_hits),
        .game_over(a_over), .win(a_win)
    );

    battleship_attack_engine #(.MAX_SHOTS(2), .FEEDBACK_CYCLES(FB)) dut_b (
        .clk(clk), .reset(reset), .game_state_code(b_code), .map(b_map),
        .x_coord(b_x), .y_coord(b_y), .confirm_attack(b_btn), .matrix_data(b_md),
        .led_rgb(b_led), .shots_left(b_shots), .hits_count(b_hits),
        .game_over(b_over), .win(b_win)
    );

    battleship_attack_engine #(.MAX_SHOTS(12), .FEEDBACK_CYCLES(FC)) dut_c (
        .clk(clk), .reset(reset), .game_state_code(c_code), .map(c_map),
        .x_coord(c_x), .y_coord(c_y), .confirm_attack(c_btn), .matrix_data(c_md),
        .led_rgb(c_led), .shots_left(c_shots), .hits_count(c_hits),
        .game_over(c_over), .win(c_win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int cidx(input int x, input int y);
        return (5 - 1 - x) * 7 + y;
    endfunction

    // Grid model of the random-test instance: what has been shot, what holds a ship.
    bit m_ship [5][7];
    bit m_shot [5][7];
    int m_hits, m_shots, m_targets;
    bit m_over, m_win;

    function automatic logic [34:0] m_md();
        logic [34:0] e;
        e = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 7; y++)
                e[cidx(x, y)] = !m_shot[x][y] || m_ship[x][y];
        return e;
    endfunction

    task automatic a_press(input int x, input int y);
        a_x = 3'(x); a_y = 3'(y); a_btn = 1'b0;
        tick(1);
        a_btn = 1'b1;
    endtask

    task automatic b_press(input int x, input int y);
        b_x = 3'(x); b_y = 3'(y); b_btn = 1'b0;
        tick(1);
        b_btn = 1'b1;
    endtask

    task automatic c_press(input int x, input int y);
        c_x = 3'(x); c_y = 3'(y); c_btn = 1'b0;
        tick(1);
        c_btn = 1'b1;
    endtask

    task automatic c_new_game(input logic [34:0] m);
        c_map = m; c_code = 2'b01;
        tick(1);
        c_code = 2'b10;
        tick(2);
        m_targets = 0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 7; y++) begin
                m_ship[x][y] = m[cidx(x, y)];
                m_shot[x][y] = 1'b0;
                if (m_ship[x][y]) m_targets++;
            end
        m_hits = 0; m_shots = 12;
        m_over = (m_targets == 0); m_win = m_over;
        check("c_entry_over", c_over, m_over);
        check("c_entry_win", c_win, m_win);
        check("c_entry_shots", c_shots, m_shots);
        check("c_entry_md", c_md, m_md());
    endtask

    task automatic c_fire(input int x, input int y);
        bit valid;
        logic [1:0] eled;
        valid = !m_over && x < 5 && y < 7;
        eled = m_over ? (m_win ? 2'b01 : 2'b10) : 2'b00;
        if (valid) begin
            if (m_shot[x][y]) eled = 2'b11;
            else begin
                m_shot[x][y] = 1'b1;
                m_shots--;
                if (m_ship[x][y]) begin m_hits++; eled = 2'b01; end
                else eled = 2'b10;
            end
        end
        c_press(x, y);
        check("c_led", c_led, eled);
        check("c_hits", c_hits, m_hits);
        check("c_shots", c_shots, m_shots);
        check("c_md", c_md, m_md());
        if (valid) begin
            tick(FC);
            if (m_hits == m_targets) begin m_over = 1; m_win = 1; end
            else if (m_shots == 0) begin m_over = 1; m_win = 0; end
            check("c_after_over", c_over, m_over);
            check("c_after_win", c_win, m_win);
            check("c_after_led", c_led, m_over ? (m_win ? 2'b01 : 2'b10) : 2'b00);
        end else begin
            tick(1);
        end
    endtask

    typedef struct {
        int x; int y;
        logic [1:0] led;
        int hits; int shots;
        bit over; bit win;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [34:0] rm;
        int n;

        // Ships at (1,1) and (1,2); budget 12.
        vecs[0] = '{1, 1, 2'b01, 1, 11, 1'b0, 1'b0};
        vecs[1] = '{7, 0, 2'b00, 1, 11, 1'b0, 1'b0};
        vecs[2] = '{3, 6, 2'b10, 1, 10, 1'b0, 1'b0};
        vecs[3] = '{1, 1, 2'b11, 1, 10, 1'b0, 1'b0};
        vecs[4] = '{4, 7, 2'b00, 1, 10, 1'b0, 1'b0};
        vecs[5] = '{1, 2, 2'b01, 2,  9, 1'b1, 1'b1};

        reset = 1'b1;
        a_code = 2'b00; b_code = 2'b00; c_code = 2'b00;
        a_map = '0; b_map = '0; c_map = '0;
        a_x = '0; a_y = '0; b_x = '0; b_y = '0; c_x = '0; c_y = '0;
        a_btn = 1'b1; b_btn = 1'b1; c_btn = 1'b1;
        #3;
        check("rst_led", a_led, 2'b00);
        check("rst_shots", a_shots, 20);
        check("rst_hits", a_hits, 0);
        check("rst_over", a_over, 0);
        check("rst_win", a_win, 0);
        check("rst_md_off", a_md, 35'd0);
        tick(1);
        reset = 1'b0;

        // Directed game on the default instance.
        a_map = (35'd1 << 34) | (35'd1 << 33);
        a_code = 2'b01;
        tick(1);
        check("a_prep_md", a_md, (35'd1 << 34) | (35'd1 << 33));
        a_code = 2'b11;
        tick(1);
        check("a_prep11_md", a_md, (35'd1 << 34) | (35'd1 << 33));
        a_code = 2'b10;
        tick(1);
        check("a_entry_shots", a_shots, 20);
        check("a_entry_md", a_md, ALL1);

        a_press(0, 6);
        check("a_hit_led", a_led, 2'b01);
        check("a_hit_hits", a_hits, 1);
        check("a_hit_shots", a_shots, 19);
        tick(FA - 1);
        check("a_fb_still_on", a_led, 2'b01);
        tick(1);
        check("a_fb_off", a_led, 2'b00);
        check("a_fb_not_over", a_over, 0);

        a_press(4, 0);
        check("a_miss_led", a_led, 2'b10);
        check("a_miss_shots", a_shots, 18);
        check("a_miss_md0", a_md[0], 1'b0);
        tick(FA);
        a_press(4, 0);
        check("a_rep_led", a_led, 2'b11);
        check("a_rep_shots", a_shots, 18);
        check("a_rep_hits", a_hits, 1);
        tick(FA);

        a_press(0, 7);
        check("a_oob_led", a_led, 2'b00);
        check("a_oob_shots", a_shots, 18);
        tick(1);

        a_press(0, 5);
        check("a_hit2_hits", a_hits, 2);
        check("a_hit2_shots", a_shots, 17);
        tick(FA);
        check("a_win_over", a_over, 1);
        check("a_win_win", a_win, 1);
        check("a_win_led", a_led, 2'b01);
        a_press(2, 2);
        tick(2);
        check("a_over_shots", a_shots, 17);
        check("a_over_led", a_led, 2'b01);

        a_code = 2'b00;
        tick(1);
        check("a_off_over", a_over, 0);
        check("a_off_led", a_led, 2'b00);
        check("a_off_hits_kept", a_hits, 2);
        check("a_off_md", a_md, 35'd0);
        a_code = 2'b10;
        tick(1);
        check("a_reentry_shots", a_shots, 20);
        check("a_reentry_hits", a_hits, 0);
        check("a_reentry_md", a_md, ALL1);

        a_press(2, 3);
        check("a_fb2_led", a_led, 2'b10);
        tick(100);
        a_code = 2'b00;
        tick(1);
        check("a_midfb_off_led", a_led, 2'b00);

        a_code = 2'b10;
        tick(1);
        a_press(4, 0);
        tick(FA);
        check("a_armed_shots", a_shots, 19);
        reset = 1'b1;
        #1;
        check("a_async_shots", a_shots, 20);
        check("a_async_led", a_led, 2'b00);
        check("a_async_md", a_md, ALL1);
        a_code = 2'b00;
        tick(1);
        reset = 1'b0;

        // Two-shot instance: held button, budget exhaustion, last-shot win priority.
        b_map = 35'd1 << 34;
        b_code = 2'b01; tick(1);
        b_code = 2'b10; tick(1);
        b_x = 3'd4; b_y = 3'd0; b_btn = 1'b0;
        tick(1);
        check("b_hold_first", b_shots, 1);
        check("b_hold_led", b_led, 2'b10);
        tick(9999);
        check("b_hold_once", b_shots, 1);
        check("b_hold_armed", b_over, 0);
        b_btn = 1'b1;
        tick(1);
        b_press(3, 0);
        check("b_last_shots", b_shots, 0);
        tick(FB);
        check("b_lose_over", b_over, 1);
        check("b_lose_win", b_win, 0);
        check("b_lose_led", b_led, 2'b10);
        b_press(0, 6);
        tick(1);
        check("b_lose_hits", b_hits, 0);

        b_code = 2'b00; tick(1);
        b_code = 2'b10; tick(1);
        b_press(4, 0);
        tick(FB);
        b_press(0, 6);
        check("b_prio_shots", b_shots, 0);
        check("b_prio_hits", b_hits, 1);
        tick(FB);
        check("b_prio_over", b_over, 1);
        check("b_prio_win", b_win, 1);
        check("b_prio_led", b_led, 2'b01);
        b_code = 2'b00;

        // Table vectors on the small instance.
        c_new_game((35'd1 << cidx(1, 1)) | (35'd1 << cidx(1, 2)));
        for (int i = 0; i < 6; i++) begin
            c_press(vecs[i].x, vecs[i].y);
            check("t_led", c_led, vecs[i].led);
            check("t_hits", c_hits, vecs[i].hits);
            check("t_shots", c_shots, vecs[i].shots);
            if (vecs[i].led != 2'b00) begin
                tick(FC);
                check("t_over", c_over, vecs[i].over);
                check("t_win", c_win, vecs[i].win);
            end else begin
                tick(1);
            end
        end
        c_code = 2'b00;
        tick(1);

        // Random games against the grid model.
        for (int g = 0; g < 8; g++) begin
            rm = '0;
            if (g == 1) rm = 35'd1 << $urandom_range(0, 34);
            else if (g > 1)
                for (int i = 0; i < 35; i++) rm[i] = ($urandom_range(0, 5) == 0);
            c_new_game(rm);
            n = 0;
            while (!m_over && n < 80) begin
                c_fire($urandom_range(0, 5), $urandom_range(0, 7));
                n++;
            end
            c_fire($urandom_range(0, 4), $urandom_range(0, 6));
            c_code = 2'b00;
            tick(1);
            check("c_exit_over", c_over, 0);
            check("c_exit_led", c_led, 2'b00);
            check("c_exit_md", c_md, 35'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
